// File: rtl/vx_sfu_pe_router_if.sv
// +----------------------------------------------------------------------------+
// | vx_sfu_pe_router_if                                                         |
// | Request, PE issue, PE commit and merged commit buses of the SFU PE router.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vx_sfu_pe_router_if #(
  parameter int NUM_LANES = 4,
  parameter int PE_COUNT  = 5,
  parameter int OPW       = 4,
  parameter int NW_BITS   = 4,
  parameter int REQ_DATAW = 128,
  parameter int RSP_DATAW = 160
);
  localparam int PE_SEL_BITS = $clog2(PE_COUNT);

  logic                          in_valid;
  logic [OPW-1:0]                in_op_type;
  logic [NW_BITS-1:0]            in_wid;
  logic [NUM_LANES-1:0]          in_tmask;
  logic [REQ_DATAW-1:0]          in_data;
  logic                          in_ready;

  logic [PE_COUNT-1:0]           pe_valid;
  logic [OPW-1:0]                pe_op_type;
  logic [NW_BITS-1:0]            pe_wid;
  logic [NUM_LANES-1:0]          pe_tmask;
  logic [REQ_DATAW-1:0]          pe_data;
  logic [PE_COUNT-1:0]           pe_ready;

  logic [PE_COUNT-1:0]           rsp_valid;
  logic [PE_COUNT*RSP_DATAW-1:0] rsp_data;
  logic [PE_COUNT-1:0]           rsp_eop;
  logic [PE_COUNT-1:0]           rsp_ready;

  logic                          commit_valid;
  logic [RSP_DATAW-1:0]          commit_data;
  logic                          commit_eop;
  logic [PE_SEL_BITS-1:0]        commit_pe;
  logic                          commit_ready;

  logic                          idle;

  // Dispatch, PEs and gather together, as seen from outside the router
  modport master (
    output in_valid, in_op_type, in_wid, in_tmask, in_data, pe_ready,
           rsp_valid, rsp_data, rsp_eop, commit_ready,
    input  in_ready, pe_valid, pe_op_type, pe_wid, pe_tmask, pe_data,
           rsp_ready, commit_valid, commit_data, commit_eop, commit_pe, idle
  );

  modport slave (
    input  in_valid, in_op_type, in_wid, in_tmask, in_data, pe_ready,
           rsp_valid, rsp_data, rsp_eop, commit_ready,
    output in_ready, pe_valid, pe_op_type, pe_wid, pe_tmask, pe_data,
           rsp_ready, commit_valid, commit_data, commit_eop, commit_pe, idle
  );
endinterface

`default_nettype wire

// File: rtl/vx_sfu_pe_router.sv
// +----------------------------------------------------------------------------+
// | vx_sfu_pe_router                                                            |
// | Routes SFU requests to PEs by op-type table with per-PE credits, and merges |
// | PE commits round-robin into a 2-entry commit FIFO.                          |
// | Option: SFU_ROUTER_PERF_EN adds saturating stall counters.                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vx_sfu_pe_router #(
  parameter int NUM_LANES    = 4,
  parameter int PE_COUNT     = 5,
  parameter int OPW          = 4,
  parameter int NW_BITS      = 4,
  parameter int REQ_DATAW    = 128,
  parameter int RSP_DATAW    = 160,
  parameter int MAX_INFLIGHT = 4,
  parameter logic [PE_COUNT*(2**OPW)-1:0] PE_OP_MAP = '0
) (
  input  logic clk,
  input  logic reset,
  vx_sfu_pe_router_if.slave bus
`ifdef SFU_ROUTER_PERF_EN
  ,
  output logic [31:0] perf_credit_stall,
  output logic [31:0] perf_pe_stall,
  output logic [31:0] perf_commit_stall
`endif
);
  localparam int c_OPS   = 2**OPW;
  localparam int c_SEL_W = $clog2(PE_COUNT);
  localparam int c_CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int c_CW1   = c_CNT_W + 1;
  localparam int c_ENT_W = RSP_DATAW + 1 + c_SEL_W;

  logic                 r_staged;
  logic [c_SEL_W-1:0]   r_sel;
  logic [c_CNT_W-1:0]   r_credit [PE_COUNT];
  logic [c_SEL_W-1:0]   r_rr_ptr;
  logic                 r_lock;
  logic [c_SEL_W-1:0]   r_lock_pe;
  logic [c_ENT_W-1:0]   r_mem [2];
  logic                 r_wptr, r_rptr;
  logic [1:0]           r_count;

  logic [c_SEL_W-1:0]   w_sel, w_gsel;
  logic                 w_gany, w_staged_hit, w_credit_ok, w_in_fire, w_pe_fire;
  logic                 w_pop, w_can_push, w_push, w_credit_zero;
  logic [c_CNT_W:0]     w_need;
  logic [PE_COUNT-1:0]  w_inc, w_dec;

  // Lowest-numbered PE claiming the op wins; unclaimed ops fall back to PE 0
  always_comb begin
    w_sel = '0;
    for (int p = PE_COUNT - 1; p >= 0; p--)
      if (PE_OP_MAP[p*c_OPS + int'(bus.in_op_type)]) w_sel = c_SEL_W'(p);
  end

  // The staged entry is not yet in the credit count, so it is added here to
  // keep the count from ever exceeding MAX_INFLIGHT
  assign w_staged_hit = r_staged & (r_sel == w_sel);
  assign w_need       = c_CW1'(r_credit[w_sel]) + c_CW1'(w_staged_hit) - c_CW1'(w_dec[w_sel]);
  assign w_credit_ok  = w_need < c_CW1'(MAX_INFLIGHT);
  assign w_pe_fire    = r_staged & bus.pe_ready[r_sel];
  assign bus.in_ready = (!r_staged | bus.pe_ready[r_sel]) & w_credit_ok;
  assign w_in_fire    = bus.in_valid & bus.in_ready;

  always_comb begin
    bus.pe_valid = '0;
    if (r_staged) bus.pe_valid[r_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_staged       <= 1'b0;
      r_sel          <= '0;
      bus.pe_op_type <= '0;
      bus.pe_wid     <= '0;
      bus.pe_tmask   <= '0;
      bus.pe_data    <= '0;
    end else if (w_in_fire) begin
      r_staged       <= 1'b1;
      r_sel          <= w_sel;
      bus.pe_op_type <= bus.in_op_type;
      bus.pe_wid     <= bus.in_wid;
      bus.pe_tmask   <= bus.in_tmask;
      bus.pe_data    <= bus.in_data;
    end else if (w_pe_fire) begin
      r_staged <= 1'b0;
    end
  end

  assign w_inc = bus.pe_valid & bus.pe_ready;
  assign w_dec = bus.rsp_valid & bus.rsp_ready & bus.rsp_eop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < PE_COUNT; p++) r_credit[p] <= '0;
    end else begin
      for (int p = 0; p < PE_COUNT; p++) begin
        if (w_inc[p] && !w_dec[p])      r_credit[p] <= r_credit[p] + c_CNT_W'(1);
        else if (!w_inc[p] && w_dec[p]) r_credit[p] <= r_credit[p] - c_CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  for (genvar p = 0; p < PE_COUNT; p++) begin : g_credit_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(w_dec[p] && !w_inc[p] && r_credit[p] == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(w_inc[p] && !w_dec[p] && r_credit[p] == c_CNT_W'(MAX_INFLIGHT)));
  end
`endif

  // Round-robin from r_rr_ptr, unless a multi-beat commit holds the grant
  always_comb begin : arb
    int idx;
    idx    = 0;
    w_gsel = r_lock_pe;
    w_gany = r_lock;
    if (!r_lock) begin
      for (int i = PE_COUNT - 1; i >= 0; i--) begin
        idx = int'(r_rr_ptr) + i;
        if (idx >= PE_COUNT) idx = idx - PE_COUNT;
        if (bus.rsp_valid[idx]) begin
          w_gsel = c_SEL_W'(idx);
          w_gany = 1'b1;
        end
      end
    end
  end

  assign w_pop      = (r_count != 2'd0) & bus.commit_ready;
  assign w_can_push = (r_count != 2'd2) | w_pop;
  assign w_push     = w_gany & w_can_push & bus.rsp_valid[w_gsel];

  always_comb begin
    bus.rsp_ready = '0;
    if (w_gany && w_can_push) bus.rsp_ready[w_gsel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_pe <= '0;
    end else if (w_push) begin
      r_rr_ptr  <= (int'(w_gsel) == PE_COUNT - 1) ? '0 : w_gsel + c_SEL_W'(1);
      r_lock    <= !bus.rsp_eop[w_gsel];
      r_lock_pe <= w_gsel;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {bus.rsp_data[int'(w_gsel)*RSP_DATAW +: RSP_DATAW],
                        bus.rsp_eop[w_gsel], w_gsel};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.commit_valid = (r_count != 2'd0);
  assign {bus.commit_data, bus.commit_eop, bus.commit_pe} = r_mem[r_rptr];

  always_comb begin
    w_credit_zero = 1'b1;
    for (int p = 0; p < PE_COUNT; p++)
      if (r_credit[p] != '0) w_credit_zero = 1'b0;
  end

  assign bus.idle = !r_staged & w_credit_zero & (r_count == 2'd0);

`ifdef SFU_ROUTER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_credit_stall <= '0;
      perf_pe_stall     <= '0;
      perf_commit_stall <= '0;
    end else begin
      if (bus.in_valid && !w_credit_ok && !(&perf_credit_stall))
        perf_credit_stall <= perf_credit_stall + 32'd1;
      if (r_staged && !bus.pe_ready[r_sel] && !(&perf_pe_stall))
        perf_pe_stall <= perf_pe_stall + 32'd1;
      if (bus.commit_valid && !bus.commit_ready && !(&perf_commit_stall))
        perf_commit_stall <= perf_commit_stall + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
